dedup_stream_ctrl: RTL and testbench

DEDUP_STREAM_CTRL -- requirements
Module: dedup_stream_ctrl

---
 rtl/dedup_stream_ctrl.sv | 97 +++++++++
 tb/tb_dedup_stream_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dedup_stream_ctrl.sv
// Frame de-duplicator: loads FRAME_LEN samples, keeps first occurrences in order, then streams them out.
// Optional build macro DEDUP_DROP_ZERO_EN: zero samples count toward the frame but are never stored.
module dedup_stream_ctrl #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [3:0]        uniq_count,
    output logic              done,
    output logic              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in LOAD and out_valid only in EMIT, so the two never overlap.
    typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

    state_t            state;
    logic [DATA_W-1:0] entries [FRAME_LEN];
    logic [3:0]        cnt;
    logic [3:0]        idx;
    logic [3:0]        frame_cnt;
    logic              hit;
    logic              keep;
    logic [3:0]        cnt_next;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < int'(cnt) && entries[i] == in_data) hit = 1'b1;
        end
    end

`ifdef DEDUP_DROP_ZERO_EN
    assign keep = !hit && (in_data != '0);
`else
    assign keep = !hit;
`endif

    assign cnt_next  = cnt + {3'b000, keep};
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT) && (cnt != 4'd0);
    assign out_last  = out_valid && (idx == cnt - 4'd1);
    assign out_data  = out_valid ? entries[idx] : '0;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= 4'd0;
            idx        <= 4'd0;
            frame_cnt  <= 4'd0;
            uniq_count <= 4'd0;
            done       <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) entries[i] <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abort wins over any coincident transfer; uniq_count keeps the last full frame.
                state     <= LOAD;
                cnt       <= 4'd0;
                idx       <= 4'd0;
                frame_cnt <= 4'd0;
            end else if (state == LOAD) begin
                if (in_valid) begin
                    if (keep) entries[cnt] <= in_data;
                    cnt       <= cnt_next;
                    frame_cnt <= frame_cnt + 4'd1;
                    if (frame_cnt == 4'(FRAME_LEN - 1)) begin
                        state      <= EMIT;
                        uniq_count <= cnt_next;
                    end
                end
            end else begin
                // An empty frame (only possible when zeros are dropped) just bounces back.
                if (cnt == 4'd0 || (out_ready && out_last)) begin
                    state     <= LOAD;
                    done      <= 1'b1;
                    cnt       <= 4'd0;
                    idx       <= 4'd0;
                    frame_cnt <= 4'd0;
                end else if (out_ready) begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dedup_stream_ctrl.sv
// Directed bench for dedup_stream_ctrl with hand-computed expected output sequences.
module tb_dedup_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [3:0] uniq_count;
    logic       done;
    logic       state_dbg;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int n_cmp;
    int n_err;

    dedup_stream_ctrl #(.DATA_W(8), .FRAME_LEN(9)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .uniq_count(uniq_count), .done(done),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the first n samples of in_q, one per cycle; leaves in_valid high on the last one.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("in_ready_load", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = in_q[i];
        end
    endtask

    // Consume the emitted frame against exp_q; stall toggles out_ready 1/0.
    task automatic collect(input bit stall, input logic [3:0] exp_uniq);
        logic [7:0] e;
        logic [7:0] held;
        bit fin;
        int k;
        @(negedge clk);
        in_valid = 1'b0;
        check("latency_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() == 0) begin
            check("empty_done_early", 32'(done), 32'd0);
            @(negedge clk);
            check("empty_done", 32'(done), 32'd1);
        end else begin
            fin = 1'b0;
            k = 0;
            while (!fin && k < 100) begin
                check("emit_valid", 32'(out_valid), 32'd1);
                check("emit_in_ready", 32'(in_ready), 32'd0);
                if (stall && k[0]) begin
                    out_ready = 1'b0;
                    held = out_data;
                    @(negedge clk);
                    check("stall_hold", 32'(out_data), 32'(held));
                end else begin
                    out_ready = 1'b1;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                    check("out_last", 32'(out_last), 32'(exp_q.size() == 0));
                    check("done_early", 32'(done), 32'd0);
                    fin = (exp_q.size() == 0);
                    @(negedge clk);
                end
                k++;
            end
            if (!fin) check("emit_timeout", 32'd0, 32'd1);
            check("done_pulse", 32'(done), 32'd1);
            check("valid_after", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("uniq_count", 32'(uniq_count), 32'(exp_uniq));
        check("back_in_load", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_uniq", 32'(uniq_count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        in_q  = '{8'd5, 8'd3, 8'd5, 8'd7, 8'd3, 8'd9, 8'd1, 8'd9, 8'd5};
        exp_q = '{8'd5, 8'd3, 8'd7, 8'd9, 8'd1};
        send(9);
        collect(1'b0, 4'd5);

        in_q  = '{8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A};
        exp_q = '{8'h2A};
        send(9);
        collect(1'b0, 4'd1);

        in_q = '{8'd0, 8'd4, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
`ifdef DEDUP_DROP_ZERO_EN
        exp_q = '{8'd4};
        send(9);
        collect(1'b0, 4'd1);
`else
        exp_q = '{8'd0, 8'd4};
        send(9);
        collect(1'b0, 4'd2);
`endif

        in_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`ifdef DEDUP_DROP_ZERO_EN
        exp_q.delete();
        send(9);
        collect(1'b0, 4'd0);
`else
        exp_q = '{8'd0};
        send(9);
        collect(1'b0, 4'd1);
`endif

        in_q  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(9);
        collect(1'b1, 4'd9);

        // Flush mid-frame, coinciding with an accepted sample that must be dropped.
        in_q = '{8'd6, 8'd6, 8'd7, 8'd8};
        send(4);
        @(negedge clk);
        in_data = 8'd11;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_uniq", 32'(uniq_count), 32'd9);
        in_q  = '{8'd8, 8'd8, 8'd2, 8'd4, 8'd2, 8'd6, 8'd8, 8'd1, 8'd3};
        exp_q = '{8'd8, 8'd2, 8'd4, 8'd6, 8'd1, 8'd3};
        send(8);
        check("uniq_hold_loading", 32'(uniq_count), 32'd9);
        @(negedge clk);
        in_data = in_q[8];
        collect(1'b0, 4'd6);

        // Reset in the middle of emission.
        in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(9);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("pre_rst_data", 32'(out_data), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_uniq", 32'(uniq_count), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_q = '{8'd9, 8'd8, 8'd7, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd1};
`ifdef DEDUP_DROP_ZERO_EN
        exp_q = '{8'd9, 8'd8, 8'd7, 8'd1};
        send(9);
        collect(1'b0, 4'd4);
`else
        exp_q = '{8'd9, 8'd8, 8'd7, 8'd0, 8'd1};
        send(9);
        collect(1'b0, 4'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
